// File: rtl/hazard_ctrl.sv
// Stall/forward controller for a 5-stage MIPS pipeline with its own E/M/W shadow of (rs, rt, a3, tnew).
// Optional MDU busy stall is compiled in with `define HAZARD_MDU_STALL_EN.

module hazard_fwd_sel #(
    parameter int REG_AW = 5,
    parameter int TW     = 2
) (
    input  logic [REG_AW-1:0] reg_addr,
    input  logic [REG_AW-1:0] m_a3,
    input  logic [TW-1:0]     m_tnew,
    input  logic [REG_AW-1:0] w_a3,
    output logic [1:0]        sel
);
    // A producer still in M with tnew>0 has no value yet, so only W can supply it.
    always_comb begin
        sel = 2'd0;
        if (reg_addr != '0) begin
            if (m_a3 == reg_addr && m_tnew == '0)
                sel = 2'd1;
            else if (w_a3 == reg_addr)
                sel = 2'd2;
        end
    end
endmodule

module hazard_stall_chk #(
    parameter int REG_AW = 5,
    parameter int TW     = 2
) (
    input  logic [REG_AW-1:0] reg_addr,
    input  logic [TW-1:0]     tuse,
    input  logic [REG_AW-1:0] e_a3,
    input  logic [TW-1:0]     e_tnew,
    input  logic [REG_AW-1:0] m_a3,
    input  logic [TW-1:0]     m_tnew,
    output logic              stall
);
    assign stall = (reg_addr != '0) &&
                   ((e_a3 == reg_addr && e_tnew > tuse) ||
                    (m_a3 == reg_addr && m_tnew > tuse));
endmodule

module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int TW     = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [REG_AW-1:0] D_Rs_In,
    input  logic [REG_AW-1:0] D_Rt_In,
    input  logic [REG_AW-1:0] D_A3_In,
    input  logic              D_RegWrite_In,
    input  logic [TW-1:0]     D_Tuse_Rs_In,
    input  logic [TW-1:0]     D_Tuse_Rt_In,
    input  logic [TW-1:0]     D_Tnew_In,
`ifdef HAZARD_MDU_STALL_EN
    input  logic              D_IsMD_In,
    input  logic              MD_Start_In,
    input  logic              MD_Busy_In,
`endif
    output logic              Stall_Out,
    output logic [1:0]        Fwd_Rs_D_Out,
    output logic [1:0]        Fwd_Rt_D_Out,
    output logic [1:0]        Fwd_Rs_E_Out,
    output logic [1:0]        Fwd_Rt_E_Out,
    output logic              Fwd_Rt_M_Out
);
    logic [REG_AW-1:0] e_rs, e_rt, e_a3, m_rt, m_a3, w_a3;
    logic [TW-1:0]     e_tnew, m_tnew;

    logic [1:0][REG_AW-1:0] chk_reg;
    logic [1:0][TW-1:0]     chk_tuse;
    logic [1:0]             chk_stall;
    logic                   stall;

    assign chk_reg  = {D_Rt_In, D_Rs_In};
    assign chk_tuse = {D_Tuse_Rt_In, D_Tuse_Rs_In};

    genvar gs;
    generate
        for (gs = 0; gs < 2; gs++) begin : g_stall
            hazard_stall_chk #(.REG_AW(REG_AW), .TW(TW)) u_chk (
                .reg_addr (chk_reg[gs]),
                .tuse     (chk_tuse[gs]),
                .e_a3     (e_a3),
                .e_tnew   (e_tnew),
                .m_a3     (m_a3),
                .m_tnew   (m_tnew),
                .stall    (chk_stall[gs])
            );
        end
    endgenerate

`ifdef HAZARD_MDU_STALL_EN
    assign stall = (|chk_stall) || (D_IsMD_In && (MD_Start_In || MD_Busy_In));
`else
    assign stall = |chk_stall;
`endif
    assign Stall_Out = stall;

    // Forward points: 0 D.rs, 1 D.rt, 2 E.rs, 3 E.rt.
    logic [3:0][REG_AW-1:0] fwd_reg;
    logic [3:0][1:0]        fwd_sel;

    assign fwd_reg = {e_rt, e_rs, D_Rt_In, D_Rs_In};

    genvar gf;
    generate
        for (gf = 0; gf < 4; gf++) begin : g_fwd
            hazard_fwd_sel #(.REG_AW(REG_AW), .TW(TW)) u_sel (
                .reg_addr (fwd_reg[gf]),
                .m_a3     (m_a3),
                .m_tnew   (m_tnew),
                .w_a3     (w_a3),
                .sel      (fwd_sel[gf])
            );
        end
    endgenerate

    assign Fwd_Rs_D_Out = fwd_sel[0];
    assign Fwd_Rt_D_Out = fwd_sel[1];
    assign Fwd_Rs_E_Out = fwd_sel[2];
    assign Fwd_Rt_E_Out = fwd_sel[3];
    assign Fwd_Rt_M_Out = (m_rt != '0) && (w_a3 == m_rt);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            e_rs   <= '0;
            e_rt   <= '0;
            e_a3   <= '0;
            e_tnew <= '0;
            m_rt   <= '0;
            m_a3   <= '0;
            m_tnew <= '0;
            w_a3   <= '0;
        end else begin
            // A stall turns the instruction entering E into a bubble; older stages keep draining.
            if (stall) begin
                e_rs   <= '0;
                e_rt   <= '0;
                e_a3   <= '0;
                e_tnew <= '0;
            end else begin
                e_rs   <= D_Rs_In;
                e_rt   <= D_Rt_In;
                e_a3   <= D_RegWrite_In ? D_A3_In : '0;
                e_tnew <= D_Tnew_In;
            end
            m_rt   <= e_rt;
            m_a3   <= e_a3;
            m_tnew <= (e_tnew == '0) ? '0 : e_tnew - TW'(1);
            w_a3   <= m_a3;
        end
    end
endmodule
